// File: rtl/demux4_registered.sv
// demux4_registered: registered 1-to-4 demux, one holding register per channel,
// steered by an explicit select or round-robin, with saturating per-channel word counts.
module demux4_registered #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    input  logic             rr_mode,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] xfer_cnt0,
    output logic [CNT_W-1:0] xfer_cnt1,
    output logic [CNT_W-1:0] xfer_cnt2,
    output logic [CNT_W-1:0] xfer_cnt3,
    output logic [1:0]       rr_ptr
);
    logic [1:0]       dest;
    logic             accept;
    logic [WIDTH-1:0] data [4];
    logic [CNT_W-1:0] cnt [4];

    assign dest     = rr_mode ? rr_ptr : sel;
    // A full channel can still take a word in the cycle its consumer drains it.
    assign in_ready = rst || !out_valid[dest] || out_ready[dest];
    assign accept   = in_valid && in_ready;

    assign out_data0 = data[0];
    assign out_data1 = data[1];
    assign out_data2 = data[2];
    assign out_data3 = data[3];
    assign xfer_cnt0 = cnt[0];
    assign xfer_cnt1 = cnt[1];
    assign xfer_cnt2 = cnt[2];
    assign xfer_cnt3 = cnt[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            rr_ptr    <= '0;
            for (int n = 0; n < 4; n++) begin
                data[n] <= '0;
                cnt[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (accept && dest == 2'(n)) begin
                    data[n]      <= in_data;
                    out_valid[n] <= 1'b1;
                    if (cnt[n] != '1)
                        cnt[n] <= cnt[n] + 1'b1;
                end else if (out_ready[n]) begin
                    out_valid[n] <= 1'b0;
                end
            end
            if (accept && rr_mode)
                rr_ptr <= rr_ptr + 2'd1;
        end
    end
endmodule

// File: tb/tb_demux4_registered.sv
// tb_demux4_registered: directed vectors; expected words go into per-channel queues
// and a monitor thread pops and compares them whenever a channel handshakes.
module tb_demux4_registered;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  in_data = 0;
    logic [1:0]  sel = 0;
    logic        rr_mode = 0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [7:0]  od [4];
    logic [15:0] cnt [4];
    logic [1:0]  rr_ptr;

    logic        s_valid = 0;
    logic        s_ready;
    logic [7:0]  s_data = 0;
    logic [3:0]  s_out_valid;
    logic [7:0]  s_od [4];
    logic [2:0]  s_cnt [4];
    logic [1:0]  s_ptr;

    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [7:0]  q2 [$];
    logic [7:0]  q3 [$];
    logic [7:0]  qs [$];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    demux4_registered dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel(sel), .rr_mode(rr_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(od[0]), .out_data1(od[1]), .out_data2(od[2]), .out_data3(od[3]),
        .xfer_cnt0(cnt[0]), .xfer_cnt1(cnt[1]), .xfer_cnt2(cnt[2]), .xfer_cnt3(cnt[3]),
        .rr_ptr(rr_ptr)
    );

    demux4_registered #(.WIDTH(8), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
        .sel(2'd0), .rr_mode(1'b0), .out_valid(s_out_valid), .out_ready(4'hF),
        .out_data0(s_od[0]), .out_data1(s_od[1]), .out_data2(s_od[2]), .out_data3(s_od[3]),
        .xfer_cnt0(s_cnt[0]), .xfer_cnt1(s_cnt[1]), .xfer_cnt2(s_cnt[2]), .xfer_cnt3(s_cnt[3]),
        .rr_ptr(s_ptr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        case (ch)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic pop_check(input int ch, input logic [7:0] d);
        int sz;
        logic [7:0] e;
        sz = ch == 0 ? q0.size() : ch == 1 ? q1.size() : ch == 2 ? q2.size() : q3.size();
        checks++;
        if (sz == 0) begin
            fails++;
            $display("FAIL unexpected word on ch%0d: got %0h, expected none", ch, d);
        end else begin
            case (ch)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            if (d !== e) begin
                fails++;
                $display("FAIL ch%0d data: got %0h, expected %0h", ch, d, e);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic r, input int ch);
        logic ok;
        in_valid = 1;
        in_data = d;
        sel = s;
        rr_mode = r;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (ok) push(ch, d);
        else check("send timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); qs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int n = 0; n < 4; n++)
                        if (out_valid[n] && out_ready[n]) pop_check(n, od[n]);
                    if (s_out_valid[0]) begin
                        checks++;
                        if (qs.size() == 0) begin
                            fails++;
                            $display("FAIL sat unexpected: got %0h, expected none", s_od[0]);
                        end else if (s_od[0] !== qs[0]) begin
                            fails++;
                            $display("FAIL sat data: got %0h, expected %0h", s_od[0], qs.pop_front());
                        end else begin
                            void'(qs.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("in_ready in reset", in_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        check("rst out_valid", out_valid, 0);
        check("rst rr_ptr", rr_ptr, 0);
        for (int n = 0; n < 4; n++) check($sformatf("rst cnt%0d", n), cnt[n], 0);

        // Select steering
        send(8'hA5, 2'd2, 0, 2);
        check("t1 out_valid", out_valid, 4'b0100);
        check("t1 data2", od[2], 8'hA5);
        check("t1 cnt2", cnt[2], 1);
        check("t1 cnt0", cnt[0], 0);
        check("t1 cnt1", cnt[1], 0);
        check("t1 cnt3", cnt[3], 0);

        // Backpressure on channel 1, then drain and load in one cycle
        out_ready = 4'b1101;
        send(8'h11, 2'd1, 0, 1);
        in_valid = 1; in_data = 8'h22; sel = 2'd1;
        @(negedge clk);
        check("t2 refuse a", in_ready, 0);
        check("t2 hold a", od[1], 8'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2 refuse b", in_ready, 0);
        check("t2 valid1", out_valid[1], 1);
        check("t2 hold b", od[1], 8'h11);
        @(posedge clk); #1 out_ready = 4'hF;
        @(negedge clk);
        check("t2 ready on drain", in_ready, 1);
        @(posedge clk); #1;
        push(1, 8'h22);
        in_valid = 0;
        check("t2 valid1 stays", out_valid[1], 1);
        check("t2 data1 new", od[1], 8'h22);
        check("t2 cnt1", cnt[1], 2);

        // Round-robin, back-to-back
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 2'd0, 1, i % 4);
            check($sformatf("t3 valid w%0d", i), out_valid, 32'(1 << (i % 4)));
        end
        check("t3 rr_ptr", rr_ptr, 0);
        for (int n = 0; n < 4; n++) check($sformatf("t3 cnt%0d", n), cnt[n], 2);

        // Round-robin stall at pointer 3 while channel 0 drains
        @(posedge clk); #1 out_ready = 4'b0110;
        send(8'h33, 2'd3, 0, 3);
        send(8'h40, 2'd0, 1, 0);
        send(8'h41, 2'd0, 1, 1);
        send(8'h42, 2'd0, 1, 2);
        in_valid = 1; in_data = 8'h44; rr_mode = 1;
        @(negedge clk);
        check("t4 refuse", in_ready, 0);
        check("t4 ptr a", rr_ptr, 3);
        check("t4 valid0 held", out_valid[0], 1);
        check("t4 data3 held", od[3], 8'h33);
        @(posedge clk); #1 out_ready = 4'b0111;
        @(negedge clk);
        @(posedge clk); #1;
        check("t4 ch0 drained", out_valid[0], 0);
        check("t4 still refuse", in_ready, 0);
        check("t4 ptr b", rr_ptr, 3);
        out_ready = 4'hF;
        @(negedge clk);
        check("t4 accept", in_ready, 1);
        @(posedge clk); #1;
        push(3, 8'h44);
        in_valid = 0;
        check("t4 data3", od[3], 8'h44);
        check("t4 valid3", out_valid[3], 1);
        check("t4 ptr wrap", rr_ptr, 0);

        // Reset mid-operation with all channels full
        @(posedge clk); #1 out_ready = 4'h0;
        send(8'h50, 2'd0, 1, 0);
        send(8'h51, 2'd0, 1, 1);
        send(8'h52, 2'd2, 0, 2);
        send(8'h53, 2'd3, 0, 3);
        check("t5 ptr", rr_ptr, 2);
        check("t5 full", out_valid, 4'hF);
        rst = 1; in_valid = 1; in_data = 8'hEE; sel = 2'd0; rr_mode = 0;
        @(negedge clk);
        check("t5 ready in rst", in_ready, 1);
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); qs.delete();
        @(negedge clk);
        check("t5 valid", out_valid, 0);
        check("t5 ptr0", rr_ptr, 0);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("t5 data%0d", n), od[n], 0);
            check($sformatf("t5 cnt%0d", n), cnt[n], 0);
        end
        out_ready = 4'hF;

        // Saturation on the 3-bit counter instance
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1; s_data = 8'(8'h60 + i);
            @(negedge clk);
            check($sformatf("t6 ready w%0d", i), s_ready, 1);
            @(posedge clk); #1;
            qs.push_back(s_data);
            check($sformatf("t6 cnt w%0d", i), s_cnt[0], (i + 1 > 7) ? 7 : i + 1);
        end
        s_valid = 0;

        repeat (3) @(posedge clk);
        #1;
        check("end q0 empty", q0.size(), 0);
        check("end q1 empty", q1.size(), 0);
        check("end q2 empty", q2.size(), 0);
        check("end q3 empty", q3.size(), 0);
        check("end qs empty", qs.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
